alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: requester 0 is the main execute stage, requester 1 is the address/compare helper.
- Round-robin arbitration selects one request per cycle and drives the ALU operand/op/shift lines.
- The ALU result is captured into a one-entry output register with valid/ready backpressure.
- Sits between the execute-stage issue logic and the ALU instance.

---
 rtl/alu_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters (0 = execute stage,
// 1 = address/compare helper). A round-robin grant picks at most one request
// per cycle, steers its operands onto the ALU lines, and captures the ALU
// result into a one-entry output register with valid/ready backpressure.
//
// Optional build macro: ALU_ARB_LOCK_EN
//   Defined   : a requester that handshakes with rN_lock=1 keeps priority
//               for up to MAX_LOCK consecutive grants while valid & lock
//               stay high.
//   Undefined : rN_lock inputs are ignored; pure round-robin.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   rN_valid / rN_ready          request handshake, N = 0, 1
//   rN_a, rN_b, rN_op, rN_s      operands, opcode, shift amount
//   rN_tag, rN_lock              opaque tag, lock request
//   alu_a, alu_b, alu_op, alu_s  drive to the shared ALU (0 when idle)
//   alu_out                      combinational result from the ALU
//   rsp_valid / rsp_ready        result handshake
//   rsp_id, rsp_tag, rsp_data    winning requester, its tag, ALU result
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int TAGW     = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [31:0]     r0_a,
    input  logic [31:0]     r0_b,
    input  logic [3:0]      r0_op,
    input  logic [4:0]      r0_s,
    input  logic [TAGW-1:0] r0_tag,
    input  logic            r0_lock,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [31:0]     r1_a,
    input  logic [31:0]     r1_b,
    input  logic [3:0]      r1_op,
    input  logic [4:0]      r1_s,
    input  logic [TAGW-1:0] r1_tag,
    input  logic            r1_lock,

    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_op,
    output logic [4:0]      alu_s,
    input  logic [31:0]     alu_out,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [TAGW-1:0] rsp_tag,
    output logic [31:0]     rsp_data
);

    // Undefined opcode: the ALU output is stale for it, so the result is zeroed.
    localparam logic [3:0] OP_UNDEF = 4'b1111;

    logic            rsp_valid_reg;
    logic            rsp_id_reg;
    logic [TAGW-1:0] rsp_tag_reg;
    logic [31:0]     rsp_data_reg;
    logic            last_reg;      // index of the most recent winner

    logic [1:0]      req_valid;
    logic [1:0]      grant;
    logic            accept;
    logic            pri;           // preferred requester when both are valid
    logic            handshake;
    logic            win;
    logic [TAGW-1:0] win_tag;

    assign req_valid = {r1_valid, r0_valid};

    // A new op may enter when the result slot is empty or being drained.
    assign accept = ~rsp_valid_reg | rsp_ready;

`ifdef ALU_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [1:0]    req_lock;
    logic [CW-1:0] lock_cnt_reg;
    logic [CW-1:0] lock_cnt_next;
    logic [CW-1:0] lock_inc;
    logic          owner_holds;

    assign req_lock = {r1_lock, r0_lock};

    // While a lock is running, the owner is always last_reg, because every
    // handshake moves the pointer to its winner.
    assign owner_holds = req_valid[last_reg] & req_lock[last_reg];
    assign pri = ((lock_cnt_reg != '0) && owner_holds) ? last_reg : ~last_reg;

    always_comb begin
        lock_inc      = CW'(1);
        lock_cnt_next = lock_cnt_reg;
        if (handshake) begin
            if (req_lock[win]) begin
                // Continue the owner's streak, or start a fresh one.
                if ((lock_cnt_reg != '0) && (win == last_reg)) begin
                    lock_inc = lock_cnt_reg + CW'(1);
                end
                // Streak exhausted: clear; pointer already names the owner,
                // so the other requester is preferred next.
                lock_cnt_next = (lock_inc == CW'(MAX_LOCK)) ? '0 : lock_inc;
            end else begin
                lock_cnt_next = '0;
            end
        end else if (!owner_holds) begin
            lock_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_reg <= '0;
        end else begin
            lock_cnt_reg <= lock_cnt_next;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = r0_lock ^ r1_lock ^ (MAX_LOCK > 0);
    assign pri = ~last_reg;
`endif

    // Requester gi wins if it is valid and either alone or preferred.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = accept & req_valid[gi]
                             & (~req_valid[1-gi] | (pri == 1'(gi)));
        end
    endgenerate

    assign r0_ready  = grant[0];
    assign r1_ready  = grant[1];
    assign handshake = grant[0] | grant[1];
    assign win       = grant[1];
    assign win_tag   = grant[1] ? r1_tag : r0_tag;

    // ALU operand steering; idle lines are held at zero.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        alu_s  = '0;
        if (grant[1]) begin
            alu_a  = r1_a;
            alu_b  = r1_b;
            alu_op = r1_op;
            alu_s  = r1_s;
        end else if (grant[0]) begin
            alu_a  = r0_a;
            alu_b  = r0_b;
            alu_op = r0_op;
            alu_s  = r0_s;
        end
    end

    // Result register: a handshake always loads (also replacing a result
    // being drained in the same cycle); a drain alone only drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_tag_reg   <= '0;
            rsp_data_reg  <= '0;
            last_reg      <= 1'b1;
        end else begin
            if (handshake) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= win;
                rsp_tag_reg   <= win_tag;
                rsp_data_reg  <= (alu_op == OP_UNDEF) ? 32'd0 : alu_out;
                last_reg      <= win;
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_tag   = rsp_tag_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the arbiter. A small ALU model drives alu_out from
// the DUT's ALU lines (returning junk for the undefined opcode).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int TAGW = 4;
    localparam int MAXL = 4;

    logic            clk;
    logic            rst;
    logic            r0_valid, r0_ready, r0_lock;
    logic [31:0]     r0_a, r0_b;
    logic [3:0]      r0_op;
    logic [4:0]      r0_s;
    logic [TAGW-1:0] r0_tag;
    logic            r1_valid, r1_ready, r1_lock;
    logic [31:0]     r1_a, r1_b;
    logic [3:0]      r1_op;
    logic [4:0]      r1_s;
    logic [TAGW-1:0] r1_tag;
    logic [31:0]     alu_a, alu_b, alu_out;
    logic [3:0]      alu_op;
    logic [4:0]      alu_s;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [TAGW-1:0] rsp_tag;
    logic [31:0]     rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic            m_valid;
    logic [31:0]     m_data;
    logic            m_id;
    logic [TAGW-1:0] m_tag;
    logic            m_last;
    int              m_streak;

    alu_arbiter #(.TAGW(TAGW), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_op(r0_op), .r0_s(r0_s), .r0_tag(r0_tag), .r0_lock(r0_lock),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_op(r1_op), .r1_s(r1_s), .r1_tag(r1_tag), .r1_lock(r1_lock),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                           logic [3:0] op, logic [4:0] s);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return b << s;
            4'd5:    return b >> s;
            4'd6:    return $unsigned($signed(b) >>> s);
            4'd7:    return a | b;
            4'd8:    return a ^ b;
            4'd9:    return ~(a | b);
            4'd10:   return b << a[4:0];
            4'd11:   return b >> a[4:0];
            4'd12:   return $unsigned($signed(b) >>> a[4:0]);
            4'd13:   return {b[15:0], 16'h0000};
            4'd14:   return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU: stale junk on the undefined opcode.
    always_comb begin
        alu_out = alu_fn(alu_a, alu_b, alu_op, alu_s);
        if (alu_op == 4'hF) alu_out = 32'hA5A5_5A5A;
    end

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_id     = 1'b0;
        m_tag    = '0;
        m_last   = 1'b1;
        m_streak = 0;
    endtask

    // Inputs are already driven (posedge+1). Check combinational outputs,
    // advance one clock, update the model, check the result register.
    task automatic cycle(string name);
        int              win;
        logic            acc, pri, lk;
        logic [31:0]     ea, eb;
        logic [3:0]      eop;
        logic [4:0]      es;
        logic [TAGW-1:0] etag;
        #1;
        acc = !m_valid || rsp_ready;
        pri = !m_last;
`ifdef ALU_ARB_LOCK_EN
        if (m_streak > 0 && (m_last ? (r1_valid && r1_lock) : (r0_valid && r0_lock)))
            pri = m_last;
`endif
        if (!acc || !(r0_valid || r1_valid)) win = -1;
        else if (r0_valid && !r1_valid)      win = 0;
        else if (r1_valid && !r0_valid)      win = 1;
        else                                 win = pri ? 1 : 0;
        ea = '0; eb = '0; eop = '0; es = '0; etag = '0; lk = 1'b0;
        if (win == 0) begin ea = r0_a; eb = r0_b; eop = r0_op; es = r0_s; etag = r0_tag; lk = r0_lock; end
        if (win == 1) begin ea = r1_a; eb = r1_b; eop = r1_op; es = r1_s; etag = r1_tag; lk = r1_lock; end
        chk({name, ".r0_ready"}, 32'(r0_ready), 32'(win == 0));
        chk({name, ".r1_ready"}, 32'(r1_ready), 32'(win == 1));
        chk({name, ".alu_a"}, alu_a, ea);
        chk({name, ".alu_b"}, alu_b, eb);
        chk({name, ".alu_op"}, 32'(alu_op), 32'(eop));
        chk({name, ".alu_s"}, 32'(alu_s), 32'(es));
        @(posedge clk);
        #1;
        if (win >= 0) begin
`ifdef ALU_ARB_LOCK_EN
            if (lk) begin
                m_streak = (m_streak > 0 && win == int'(m_last)) ? m_streak + 1 : 1;
                if (m_streak == MAXL) m_streak = 0;
            end else begin
                m_streak = 0;
            end
`endif
            m_valid = 1'b1;
            m_data  = (eop == 4'hF) ? 32'd0 : alu_fn(ea, eb, eop, es);
            m_id    = (win == 1);
            m_tag   = etag;
            m_last  = (win == 1);
        end else begin
            if (acc && rsp_ready) m_valid = 1'b0;
`ifdef ALU_ARB_LOCK_EN
            if (m_streak > 0 && !(m_last ? (r1_valid && r1_lock) : (r0_valid && r0_lock)))
                m_streak = 0;
`endif
        end
        chk({name, ".rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
        chk({name, ".rsp_data"}, rsp_data, m_data);
        chk({name, ".rsp_id"}, 32'(rsp_id), 32'(m_id));
        chk({name, ".rsp_tag"}, 32'(rsp_tag), 32'(m_tag));
        $display("cycle %s: id=%0d tag=%0d data=%h valid=%0d", name, rsp_id, rsp_tag, rsp_data, rsp_valid);
    endtask

    // Raise reset mid-cycle, check the asynchronous clear, release on negedge.
    task automatic do_reset(string name);
        @(posedge clk);
        #3;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk({name, ".rst_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, ".rst_data"}, rsp_data, 32'd0);
        chk({name, ".rst_id"}, 32'(rsp_id), 32'd0);
        chk({name, ".rst_tag"}, 32'(rsp_tag), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("reset %s done", name);
    endtask

    task automatic set_r0(logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                          logic [4:0] s, logic [TAGW-1:0] tag, logic lk);
        r0_valid = v; r0_a = a; r0_b = b; r0_op = op; r0_s = s; r0_tag = tag; r0_lock = lk;
    endtask

    task automatic set_r1(logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                          logic [4:0] s, logic [TAGW-1:0] tag, logic lk);
        r1_valid = v; r1_a = a; r1_b = b; r1_op = op; r1_s = s; r1_tag = tag; r1_lock = lk;
    endtask

    initial begin
        logic [31:0]     sv_data;
        logic            sv_id;
        logic [TAGW-1:0] sv_tag;
        logic [3:0]      t4_op   [4];
        logic [31:0]     t4_a    [4];
        logic [31:0]     t4_b    [4];
        logic [4:0]      t4_s    [4];
        logic [31:0]     t4_exp  [4];
        logic [4:0]      t6_exp;

        rst = 1'b1;
        rsp_ready = 1'b0;
        set_r0(1'b0, '0, '0, '0, '0, '0, 1'b0);
        set_r1(1'b0, '0, '0, '0, '0, '0, 1'b0);
        model_reset();
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_data", rsp_data, 32'd0);
        chk("reset.rsp_id", 32'(rsp_id), 32'd0);
        chk("reset.rsp_tag", 32'(rsp_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single ADD from r0
        rsp_ready = 1'b1;
        set_r0(1'b1, 32'd5, 32'd3, 4'b0000, 5'd0, 4'd2, 1'b0);
        cycle("t1");
        chk("t1.data", rsp_data, 32'd8);
        chk("t1.id", 32'(rsp_id), 32'd0);
        chk("t1.tag", 32'(rsp_tag), 32'd2);
        r0_valid = 1'b0;

        // 2: contested round-robin from reset
        do_reset("t2");
        set_r0(1'b1, 32'd1, 32'd2, 4'b0000, 5'd0, 4'd3, 1'b0);
        set_r1(1'b1, 32'd9, 32'd4, 4'b0001, 5'd0, 4'd7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle("t2");
            chk("t2.rr_id", 32'(rsp_id), 32'(i % 2));
            chk("t2.rr_valid", 32'(rsp_valid), 32'd1);
        end

        // 3: backpressure stall then same-cycle handshake
        r0_valid  = 1'b0;
        rsp_ready = 1'b0;
        set_r1(1'b1, 32'd10, 32'd3, 4'b0001, 5'd0, 4'd5, 1'b0);
        sv_data = rsp_data; sv_id = rsp_id; sv_tag = rsp_tag;
        for (int i = 0; i < 3; i++) begin
            cycle("t3_stall");
            chk("t3.hold_data", rsp_data, sv_data);
            chk("t3.hold_id", 32'(rsp_id), 32'(sv_id));
            chk("t3.hold_tag", 32'(rsp_tag), 32'(sv_tag));
        end
        rsp_ready = 1'b1;
        cycle("t3_go");
        chk("t3.data", rsp_data, 32'd7);
        chk("t3.id", 32'(rsp_id), 32'd1);
        r1_valid = 1'b0;

        // 4: shift / compare / undefined opcodes
        t4_op[0] = 4'b0110; t4_a[0] = 32'd0;          t4_b[0] = 32'h8000_0000; t4_s[0] = 5'd4; t4_exp[0] = 32'hF800_0000;
        t4_op[1] = 4'b0011; t4_a[1] = 32'hFFFF_FFFF;  t4_b[1] = 32'd1;         t4_s[1] = 5'd0; t4_exp[1] = 32'd1;
        t4_op[2] = 4'b1110; t4_a[2] = 32'hFFFF_FFFF;  t4_b[2] = 32'd1;         t4_s[2] = 5'd0; t4_exp[2] = 32'd0;
        t4_op[3] = 4'b1111; t4_a[3] = 32'h1234_5678;  t4_b[3] = 32'd1;         t4_s[3] = 5'd3; t4_exp[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            set_r0(1'b1, t4_a[i], t4_b[i], t4_op[i], t4_s[i], 4'(i), 1'b0);
            cycle("t4");
            chk("t4.data", rsp_data, t4_exp[i]);
        end

        // 5: async reset with a result pending, then first contested grant
        do_reset("t5");
        set_r0(1'b1, 32'd100, 32'd1, 4'b0000, 5'd0, 4'd1, 1'b0);
        set_r1(1'b1, 32'd200, 32'd1, 4'b0000, 5'd0, 4'd2, 1'b0);
        cycle("t5");
        chk("t5.first_id", 32'(rsp_id), 32'd0);

        // 6: r1 lock request against a contending r0
`ifdef ALU_ARB_LOCK_EN
        t6_exp = 5'b01111;
`else
        t6_exp = 5'b10101;
`endif
        do_reset("t6");
        set_r1(1'b1, 32'd7, 32'd7, 4'b0000, 5'd0, 4'd9, 1'b1);
        cycle("t6");
        chk("t6.id0", 32'(rsp_id), 32'(t6_exp[0]));
        set_r0(1'b1, 32'd1, 32'd1, 4'b0000, 5'd0, 4'd4, 1'b0);
        for (int i = 1; i < 5; i++) begin
            cycle("t6");
            chk("t6.id", 32'(rsp_id), 32'(t6_exp[i]));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(3) != 0);
            set_r0(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)),
                   5'($urandom_range(31)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            set_r1(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)),
                   5'($urandom_range(31)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
